// File: rtl/disp_pkg.sv
// disp_pkg: shared constants and the hex-to-7-segment decode used by the
// display scanner. Segment encoding is active-low {g,f,e,d,c,b,a}.
package disp_pkg;

    // Blank digit: all segments and the decimal point off.
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment patterns for hex digits 0..F (decimal point not included).
    localparam logic [6:0] HEX_SEG [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic logic [6:0] hexdec(input logic [3:0] nib);
        return HEX_SEG[nib];
    endfunction

endpackage

// File: rtl/seg7_hexdec.sv
// seg7_hexdec: combinational 4-bit hex nibble to active-low 7-segment pattern.
module seg7_hexdec
    import disp_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = hexdec(nib_i);

endmodule

// File: rtl/disp_scan_n.sv
// disp_scan_n: selects one of NCH debug channels, snapshots it once per frame
// and scans it as hex over an NDIG-digit multiplexed 7-segment display.
// Optional build macro DISP_LZB_EN enables leading-zero blanking.
module disp_scan_n
    import disp_pkg::*;
#(
    parameter int NCH   = 16,
    parameter int DW    = 32,
    parameter int PRESC = 10000,
    parameter int SELW  = 4
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [NCH*DW-1:0]   DI,
    input  logic [NCH-1:0]      VALID,
    input  logic [SELW-1:0]     SEL,
    input  logic                FREEZE,
    input  logic [DW/4-1:0]     DP,
    output logic [7:0]          SEG,
    output logic [DW/4-1:0]     AN,
    output logic [DW-1:0]       CUR,
    output logic                TICK
);

    localparam int NDIG  = DW / 4;
    localparam int NSLOT = 2 ** SELW;
    localparam int PW    = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam int IW    = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NDIG - 1);

    logic [PW-1:0]   presc_q, presc_d;
    logic [IW-1:0]   idx_q, idx_d, idx_nxt;
    logic [DW-1:0]   snap_q, snap_d;
    logic [NDIG-1:0] an_q, an_d;
    logic [7:0]      seg_q, seg_d;
    logic            tick_q;
    logic            tick;
    logic            wrap;
    logic [3:0]      nib_sel;
    logic [6:0]      seg7;

    // Channel table padded to the full select range: unimplemented or
    // invalid channels read as zero, so any SEL value is safe to index.
    logic [DW-1:0] chan [NSLOT];
    logic [3:0]    nib_arr [NDIG];

    genvar gi;
    generate
        for (gi = 0; gi < NSLOT; gi++) begin : g_chan
            if (gi < NCH) begin : g_real
                assign chan[gi] = VALID[gi] ? DI[gi*DW +: DW] : '0;
            end else begin : g_pad
                assign chan[gi] = '0;
            end
        end
        for (gi = 0; gi < NDIG; gi++) begin : g_nib
            assign nib_arr[gi] = snap_d[gi*4 +: 4];
        end
    endgenerate

`ifdef DISP_LZB_EN
    // hi_zero[k]: every nibble from k upward is zero, i.e. digit k is a leading zero.
    logic [NDIG-1:0] hi_zero;
    logic            blank;
    generate
        for (gi = 0; gi < NDIG; gi++) begin : g_lzb
            assign hi_zero[gi] = ~|snap_d[DW-1:gi*4];
        end
    endgenerate
    assign blank = (idx_nxt != '0) && hi_zero[idx_nxt];
`endif

    // Prescaler, digit index and frame-boundary snapshot next-state.
    always_comb begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        idx_nxt = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        idx_d   = tick ? idx_nxt : idx_q;
        wrap    = tick && (idx_q == IDX_LAST);
        snap_d  = snap_q;
        if (wrap && !FREEZE) begin
            snap_d = chan[SEL];
        end
    end

    assign nib_sel = nib_arr[idx_nxt];

    seg7_hexdec u_hexdec (
        .nib_i (nib_sel),
        .seg_o (seg7)
    );

    // Anode and segment next-state: only change on a digit advance, and the
    // boundary digit uses the snapshot being loaded on that same edge.
    always_comb begin
        an_d  = an_q;
        seg_d = seg_q;
        if (tick) begin
            an_d  = ~(NDIG'(1) << idx_nxt);
            seg_d = {~DP[idx_nxt], seg7};
`ifdef DISP_LZB_EN
            if (blank) begin
                seg_d = SEG_BLANK;
            end
`endif
        end
    end

    // State registers with synchronous active-low reset; reset wins over a tick.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            presc_q <= '0;
            idx_q   <= IDX_LAST;
            snap_q  <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
            tick_q  <= 1'b0;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            tick_q  <= tick;
        end
    end

    assign SEG  = seg_q;
    assign AN   = an_q;
    assign CUR  = snap_q;
    assign TICK = tick_q;

endmodule

// File: tb/tb_disp_scan_n.sv
// tb_disp_scan_n: self-checking bench for disp_scan_n (NCH=4, DW=16, PRESC=4).
// A cycle-count reference model pushes the expected {AN,SEG} at each digit
// advance; a monitor pops and compares whenever the DUT pulses TICK.
module tb_disp_scan_n;

    localparam int NCH   = 4;
    localparam int DW    = 16;
    localparam int PRESC = 4;
    localparam int SELW  = 2;
    localparam int NDIG  = DW / 4;

    localparam logic [7:0] HEXT [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

`ifdef DISP_LZB_EN
    localparam logic [7:0] ZB    = 8'hFF;
    localparam logic [7:0] ZB_DP = 8'hFF;
`else
    localparam logic [7:0] ZB    = 8'hC0;
    localparam logic [7:0] ZB_DP = 8'h40;
`endif

    logic               CLK;
    logic               RESET;
    logic [NCH*DW-1:0]  DI;
    logic [NCH-1:0]     VALID;
    logic [SELW-1:0]    SEL;
    logic               FREEZE;
    logic [NDIG-1:0]    DP;
    logic [7:0]         SEG;
    logic [NDIG-1:0]    AN;
    logic [DW-1:0]      CUR;
    logic               TICK;

    logic [DW-1:0] ch [NCH];
    assign DI = {ch[3], ch[2], ch[1], ch[0]};

    int n_vec = 0;
    int n_err = 0;

    disp_scan_n #(.NCH(NCH), .DW(DW), .PRESC(PRESC), .SELW(SELW)) dut (
        .CLK    (CLK),
        .RESET  (RESET),
        .DI     (DI),
        .VALID  (VALID),
        .SEL    (SEL),
        .FREEZE (FREEZE),
        .DP     (DP),
        .SEG    (SEG),
        .AN     (AN),
        .CUR    (CUR),
        .TICK   (TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, expv);
        end
    endtask

    // ---------------- reference model ----------------
    int            m_cnt;
    logic [DW-1:0] m_snap;
    logic          m_tick;
    logic [11:0]   exp_q [$];

    function automatic logic [DW-1:0] pick_chan();
        if (int'(SEL) < NCH && VALID[SEL]) return ch[SEL];
        return '0;
    endfunction

    function automatic logic [DW-1:0] frame_snap(input int cnt);
        int d;
        d = (cnt / PRESC) % NDIG;
        if (d == 0 && !FREEZE) return pick_chan();
        return m_snap;
    endfunction

    function automatic logic [7:0] exp_seg(input int d, input logic [DW-1:0] s);
        logic [3:0] n;
        n = s[d*4 +: 4];
`ifdef DISP_LZB_EN
        if (d != 0 && (s >> (4*d)) == 0) return 8'hFF;
`endif
        return {~DP[d], HEXT[n][6:0]};
    endfunction

    function automatic logic [11:0] exp_entry(input int cnt);
        int d;
        logic [NDIG-1:0] an;
        d  = (cnt / PRESC) % NDIG;
        an = ~(NDIG'(1) << d);
        return {an, exp_seg(d, frame_snap(cnt))};
    endfunction

    // Model state advances with the clock; a digit slot ends every PRESC cycles.
    always @(posedge CLK) begin
        if (!RESET) begin
            m_cnt  <= 0;
            m_snap <= '0;
            m_tick <= 1'b0;
        end else begin
            m_cnt  <= m_cnt + 1;
            m_tick <= ((m_cnt % PRESC) == PRESC - 1);
            if ((m_cnt % PRESC) == PRESC - 1) begin
                m_snap <= frame_snap(m_cnt);
                exp_q.push_back(exp_entry(m_cnt));
            end
        end
    end

    // Monitor: per-cycle TICK/CUR, and scoreboard pop on each digit advance.
    always @(posedge CLK) begin
        logic [11:0] e;
        #1;
        check("tick", 32'(TICK), 32'(m_tick));
        check("cur", 32'(CUR), 32'(m_snap));
        if (TICK) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("an_seg", {20'd0, AN, SEG}, {20'd0, e});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_tick();
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 * PRESC; i++) begin
            @(posedge CLK); #1;
            if (TICK) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_frame_start();
        bit seen;
        seen = 0;
        for (int i = 0; i < 4 * NDIG * PRESC; i++) begin
            @(posedge CLK); #1;
            if (TICK && AN == 4'hE) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check("frame_timeout", 32'd0, 32'd1);
    endtask

    localparam logic [3:0] AN_SEQ [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};
    localparam logic [7:0] SEG_1A3F [4] = '{8'h8E, 8'hB0, 8'h88, 8'hF9};

    initial begin
        RESET  = 1'b0;
        ch[0]  = 16'h0000;
        ch[1]  = 16'h5B2C;
        ch[2]  = 16'h1A3F;
        ch[3]  = 16'hFFFF;
        VALID  = 4'hF;
        SEL    = 2'd2;
        FREEZE = 1'b0;
        DP     = 4'h0;

        repeat (3) @(posedge CLK);
        #1;
        check("rst_an", 32'(AN), 32'hF);
        check("rst_seg", 32'(SEG), 32'hFF);
        check("rst_cur", 32'(CUR), 32'h0);
        check("rst_tick", 32'(TICK), 32'h0);
        RESET = 1'b1;

        // First frame after reset: digit order, tick spacing, ch2 = 1A3F.
        for (int i = 0; i < 16; i++) begin
            @(posedge CLK); #1;
            check("tick_seq", 32'(TICK), 32'((i % 4) == 3));
            if ((i % 4) == 3) begin
                check("an_seq", 32'(AN), 32'(AN_SEQ[i/4]));
                check("seg_1a3f", 32'(SEG), 32'(SEG_1A3F[i/4]));
                check("cur_1a3f", 32'(CUR), 32'h1A3F);
            end
        end

        // Mid-frame select change must not tear the displayed value.
        SEL = 2'd1;
        wait_frame_start();
        check("ch1_cur", 32'(CUR), 32'h5B2C);
        check("ch1_d0", 32'(SEG), 32'hC6);
        repeat (5) @(posedge CLK);
        #1;
        SEL = 2'd2;
        wait_tick();
        check("ch1_d2_an", 32'(AN), 32'hB);
        check("ch1_d2", 32'(SEG), 32'h83);
        wait_tick();
        check("ch1_d3", 32'(SEG), 32'h92);
        check("ch1_hold", 32'(CUR), 32'h5B2C);
        wait_tick();
        check("ch2_an", 32'(AN), 32'hE);
        check("ch2_d0", 32'(SEG), 32'h8E);
        check("ch2_cur", 32'(CUR), 32'h1A3F);

        // Freeze across a boundary while the source changes.
        FREEZE = 1'b1;
        ch[2]  = 16'h00C4;
        wait_frame_start();
        check("frz_cur", 32'(CUR), 32'h1A3F);
        check("frz_d0", 32'(SEG), 32'h8E);
        FREEZE = 1'b0;
        wait_frame_start();
        check("unfrz_cur", 32'(CUR), 32'h00C4);
        check("unfrz_d0", 32'(SEG), 32'h99);

        // Invalid channel reads as zero; DP only on digit 2.
        SEL   = 2'd3;
        VALID = 4'h7;
        DP    = 4'b0100;
        wait_frame_start();
        check("inv_cur", 32'(CUR), 32'h0);
        check("inv_d0", 32'(SEG), 32'hC0);
        wait_tick();
        check("inv_d1", 32'(SEG), 32'(ZB));
        wait_tick();
        check("inv_d2_an", 32'(AN), 32'hB);
        check("inv_d2", 32'(SEG), 32'(ZB_DP));
        wait_tick();
        check("inv_d3", 32'(SEG), 32'(ZB));

        // One-cycle reset in the middle of a frame.
        SEL   = 2'd1;
        VALID = 4'hF;
        DP    = 4'h0;
        wait_frame_start();
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        check("mrst_an", 32'(AN), 32'hF);
        check("mrst_seg", 32'(SEG), 32'hFF);
        check("mrst_cur", 32'(CUR), 32'h0);
        RESET = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            check("mrst_tick", 32'(TICK), 32'(i == 3));
        end
        check("mrst_an0", 32'(AN), 32'hE);
        check("mrst_seg0", 32'(SEG), 32'hC6);

        // Random traffic, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            @(posedge CLK); #1;
            SEL    = SELW'($urandom_range(0, 3));
            FREEZE = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 7) == 0) DP = NDIG'($urandom);
            if ($urandom_range(0, 7) == 0) VALID = NCH'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                ch[$urandom_range(0, 3)] = ($urandom_range(0, 1) == 0) ?
                    DW'($urandom_range(0, 255)) : DW'($urandom);
            end
        end

        repeat (2) @(posedge CLK);
        #2;
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
